// File: rtl/gf2_os_mac.sv
// Streaming GF(2) multiply-accumulate: per beat, XOR of LANES carry-less products,
// XOR-accumulated over first/last-delimited groups; a fixed accumulator window per group.
module gf2_os_mac #(
  parameter int W       = 8,
  parameter int LANES   = 2,
  parameter int OUT_W   = 7,
  parameter int OUT_OFS = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_y,
  output logic [CNT_W-1:0]     out_beats,
  output logic                 drop_pulse
);
  localparam int PW = 2*W-1;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  function automatic logic [PW-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        r[i+j] = r[i+j] ^ (a[i] & b[j]);
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] lane_xor(input logic [LANES*W-1:0] a,
                                             input logic [LANES*W-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      r = r ^ clmul(a[l*W +: W], b[l*W +: W]);
    end
    return r;
  endfunction

  logic [PW-1:0]    p_r;
  logic             s1_valid_r;
  logic             s1_first_r;
  logic             s1_last_r;
  logic [PW-1:0]    acc_r;
  logic [CNT_W-1:0] cnt_r;
  state_t           state_r;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_y_r;
  logic [CNT_W-1:0] out_beats_r;
  logic             drop_pulse_r;

  logic             s2_adv_s;
  logic             in_ready_s;
  logic             fire_s;
  logic [PW-1:0]    acc_base_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic [PW-1:0]    acc_n_s;
  logic [CNT_W-1:0] cnt_n_s;

  // Handshake decode and next accumulator/count for the beat held in S1
  always_comb begin
    s2_adv_s   = s1_valid_r & ~(out_valid_r & ~out_ready);
    in_ready_s = ~s1_valid_r | s2_adv_s;
    fire_s     = in_valid & in_ready_s;
    if ((state_r == IDLE) || s1_first_r) begin
      acc_base_s = '0;
      cnt_base_s = '0;
    end else begin
      acc_base_s = acc_r;
      cnt_base_s = cnt_r;
    end
    acc_n_s = acc_base_s ^ p_r;
    if (&cnt_base_s) begin
      cnt_n_s = cnt_base_s;
    end else begin
      cnt_n_s = cnt_base_s + CNT_W'(1);
    end
  end

  // Stage S1: lane products reduced and registered with the group flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_r        <= '0;
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end else if (fire_s) begin
      p_r        <= lane_xor(in_a, in_b);
      s1_valid_r <= 1'b1;
      s1_first_r <= in_first;
      s1_last_r  <= in_last;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage S2: group FSM, accumulator and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r        <= '0;
      cnt_r        <= '0;
      state_r      <= IDLE;
      out_valid_r  <= 1'b0;
      out_y_r      <= '0;
      out_beats_r  <= '0;
      drop_pulse_r <= 1'b0;
    end else begin
      drop_pulse_r <= 1'b0;
      if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (s2_adv_s) begin
        // A first beat landing on an open group throws the old partial away
        drop_pulse_r <= s1_first_r & (state_r == ACCUM);
        if (s1_last_r) begin
          out_y_r     <= acc_n_s[OUT_OFS +: OUT_W];
          out_beats_r <= cnt_n_s;
          out_valid_r <= 1'b1;
          acc_r       <= '0;
          cnt_r       <= '0;
          state_r     <= IDLE;
        end else begin
          acc_r   <= acc_n_s;
          cnt_r   <= cnt_n_s;
          state_r <= ACCUM;
        end
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_y      = out_y_r;
  assign out_beats  = out_beats_r;
  assign drop_pulse = drop_pulse_r;

endmodule

// File: tb/tb_gf2_os_mac.sv
// Scoreboard bench for gf2_os_mac: two instances (window at bit 0 and bit 8) share stimulus;
// expected group results are queued at input acceptance and checked as results leave.
module tb_gf2_os_mac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic        in_ready, out_valid, drop_pulse;
  logic        in_ready2, out_valid2, drop_pulse2;
  logic [6:0]  out_y, out_y2;
  logic [7:0]  out_beats, out_beats2;

  typedef struct packed {
    logic [14:0] acc;
    logic [7:0]  beats;
  } res_t;

  res_t        exp_q[$];
  res_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          drop_seen = 0;
  int          drop_exp = 0;
  logic [14:0] m_acc = 15'h0000;
  logic [7:0]  m_cnt = 8'h00;
  bit          m_open = 1'b0;

  always #5 clk = ~clk;

  gf2_os_mac #(.W(8), .LANES(2), .OUT_W(7), .OUT_OFS(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_beats(out_beats), .drop_pulse(drop_pulse));

  gf2_os_mac #(.W(8), .LANES(2), .OUT_W(7), .OUT_OFS(8), .CNT_W(8)) dut_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2),
    .out_beats(out_beats2), .drop_pulse(drop_pulse2));

  function automatic logic [14:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] r;
    r = 15'h0000;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ ({7'h00, a} << i);
    end
    return r;
  endfunction

  // Scoreboard: every result handshake is popped and compared against both windows
  always @(negedge clk) begin
    if (drop_pulse) drop_seen++;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got out_y=%h out_beats=%0d, no result pending", out_y, out_beats);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_y !== mon_e.acc[6:0] || out_beats !== mon_e.beats) begin
          n_fail++;
          $display("FAIL result_lo: got y=%h beats=%0d, want y=%h beats=%0d",
                   out_y, out_beats, mon_e.acc[6:0], mon_e.beats);
        end
        n_checks++;
        if (out_valid2 !== 1'b1 || out_y2 !== mon_e.acc[14:8]) begin
          n_fail++;
          $display("FAIL result_hi: got valid=%b y=%h, want valid=1 y=%h",
                   out_valid2, out_y2, mon_e.acc[14:8]);
        end
      end
    end
  end

  task automatic model_accept(input logic [15:0] a, input logic [15:0] b,
                              input logic f, input logic l);
    logic [14:0] p;
    p = ref_mul(a[7:0], b[7:0]) ^ ref_mul(a[15:8], b[15:8]);
    if (f && m_open) drop_exp++;
    if (f || !m_open) begin
      m_acc = 15'h0000;
      m_cnt = 8'h00;
    end
    m_acc = m_acc ^ p;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    if (l) begin
      exp_q.push_back({m_acc, m_cnt});
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                           input logic f, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=%b after %0d cycles, want 1", in_ready, t);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      model_accept(a, b, f, l);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_y, out_beats, drop_pulse, out_valid2, out_y2, out_beats2} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b y=%h n=%0d d=%b, want all 0", out_valid, out_y, out_beats, drop_pulse);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    rst_n = 1'b1; m_open = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_beat(16'h0003, 16'h0003, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got out_valid=%b one edge after accept, want 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 7'h05 || out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL single_beat: got v=%b y=%h n=%0d, want v=1 y=05 n=1", out_valid, out_y, out_beats);
    end
    drain();
  endtask

  task automatic test_lane_cancel();
    send_beat(16'h0503, 16'h0103, 1'b1, 1'b1);
    send_beat(16'h000F, 16'h0001, 1'b1, 1'b0);
    send_beat(16'h0002, 16'h0001, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL cancel_multi_drain: got %0d results pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_window();
    send_beat(16'h0080, 16'h0080, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (out_y !== 7'h00 || out_y2 !== 7'h40) begin
      n_fail++;
      $display("FAIL window: got lo=%h hi=%h, want lo=00 hi=40", out_y, out_y2);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_beat(16'h0003, 16'h0003, 1'b1, 1'b1);
    send_beat(16'h000F, 16'h0001, 1'b1, 1'b1);
    in_valid = 1'b1; in_a = 16'h0002; in_b = 16'h0003; in_first = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 7'h05) begin
        n_fail++;
        $display("FAIL stall_hold: got rdy=%b v=%b y=%h, want rdy=0 v=1 y=05", in_ready, out_valid, out_y);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(16'h0002, 16'h0003, 1'b1, 1'b1);
    drain();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL backpressure_drain: got %0d results pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_drop();
    int d0;
    d0 = drop_seen;
    send_beat(16'h000F, 16'h0001, 1'b1, 1'b0);
    send_beat(16'h0002, 16'h0001, 1'b0, 1'b0);
    send_beat(16'h0003, 16'h0003, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (drop_pulse !== 1'b1 || out_y !== 7'h05 || out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_result: got d=%b y=%h n=%0d, want d=1 y=05 n=1", drop_pulse, out_y, out_beats);
    end
    @(negedge clk);
    n_checks++;
    if (drop_pulse !== 1'b0 || drop_seen - d0 !== 1) begin
      n_fail++;
      $display("FAIL drop_width: got d=%b pulses=%0d, want d=0 pulses=1", drop_pulse, drop_seen - d0);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    send_beat(16'h000F, 16'h0001, 1'b1, 1'b0);
    send_beat(16'h0007, 16'h0001, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_y, out_beats, drop_pulse} !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b y=%h n=%0d d=%b, want all 0", out_valid, out_y, out_beats, drop_pulse);
    end
    rst_n = 1'b1; m_open = 1'b0;
    @(posedge clk); #1;
    send_beat(16'h0003, 16'h0003, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 7'h05 || out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL post_reset_group: got v=%b y=%h n=%0d, want v=1 y=05 n=1", out_valid, out_y, out_beats);
    end
    drain();
  endtask

  task automatic test_saturation();
    send_beat(16'h0001, 16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 298; i++) send_beat(16'h0001, 16'h0001, 1'b0, 1'b0);
    send_beat(16'h0101, 16'h0001, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (out_beats !== 8'hFF) begin
      n_fail++;
      $display("FAIL saturation: got out_beats=%0d, want 255", out_beats);
    end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          send_beat(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                    (i == 79) || ($urandom_range(0, 2) == 0));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    n_checks++;
    if (exp_q.size() !== 0 || drop_seen !== drop_exp) begin
      n_fail++;
      $display("FAIL random_stream: got pending=%0d drops=%0d, want pending=0 drops=%0d",
               exp_q.size(), drop_seen, drop_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lane_cancel();
    test_window();
    test_back_to_back();
    test_drop();
    test_mid_reset();
    test_saturation();
    test_random();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at time limit, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
